// File: rtl/sram_array_2r1w_pkg.sv
// sram_pkg: shared definitions for the 2R1W storage array.
//   state_t : clear sequencer state encoding (ST_CLEAR / ST_IDLE)
//   clog2   : address width helper, usable in parameter expressions
package sram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_array_2r1w_if.sv
// sram_array_2r1w_if: access bus for the 2R1W array.
//   clr            clear request
//   we / wa / wd   write port
//   re1 / ra1      read port 1 request, rd1 its registered data
//   re2 / ra2      read port 2 request, rd2 its registered data
//   busy           clear sequencer owns the array
// master = caller side, slave = array side.
interface sram_array_2r1w_if
  import sram_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = clog2(DEPTH);

  logic             clr;
  logic             we;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] wd;
  logic             re1;
  logic [AW-1:0]    ra1;
  logic [WIDTH-1:0] rd1;
  logic             re2;
  logic [AW-1:0]    ra2;
  logic [WIDTH-1:0] rd2;
  logic             busy;

  modport master (
    output clr, we, wa, wd, re1, ra1, re2, ra2,
    input  rd1, rd2, busy
  );

  modport slave (
    input  clr, we, wa, wd, re1, ra1, re2, ra2,
    output rd1, rd2, busy
  );

endinterface

// File: rtl/sram_array_2r1w_clear_fsm.sv
// sram_clear_fsm: walks a pointer over every entry so the array can zero it.
//   clk, rst   clock, synchronous active-high reset
//   clr        start a new clear sequence (honoured only when idle)
//   busy       registered; high while the sequence owns the array
//   clr_we     write strobe for the zeroing write
//   clr_addr   entry being zeroed this cycle
//
// state    | meaning
// ST_CLEAR | zeroing mem[ptr] each cycle; busy=1
// ST_IDLE  | array available to callers; busy=0
module sram_clear_fsm
  import sram_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    case (state_q)
      ST_CLEAR: begin
        if (ptr_q == LAST) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
          busy_d  = 1'b0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  assign busy     = busy_q;
  assign clr_we   = (state_q == ST_CLEAR);
  assign clr_addr = ptr_q;

endmodule

// File: rtl/sram_array_2r1w.sv
// sram_array_2r1w: DEPTH x WIDTH storage, one write port, two registered
// read ports with write-first bypass, and a hardware clear sequencer.
//   clk   clock
//   rst   synchronous active-high reset (starts a clear, zeroes rd1/rd2)
//   bus   sram_array_2r1w_if slave: clr, write port, two read ports, busy
module sram_array_2r1w
  import sram_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input logic clk,
  input logic rst,
  sram_array_2r1w_if.slave bus
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd1_q, rd2_q;
  logic             busy;
  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             user_we;
  logic             byp1, byp2;
  logic [WIDTH-1:0] rdata1, rdata2;

  // Extra bit keeps the compare meaningful when DEPTH is a power of two.
  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < (AW+1)'(DEPTH));
  endfunction

  sram_clear_fsm #(.DEPTH(DEPTH)) u_clear (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A clear request wins over a same-cycle write; the bypass must then not
  // forward data that never reaches the array.
  assign user_we = bus.we && !clr_we && !bus.clr && in_range(bus.wa);
  assign byp1    = user_we && (bus.wa == bus.ra1);
  assign byp2    = user_we && (bus.wa == bus.ra2);
  assign rdata1  = in_range(bus.ra1) ? mem[bus.ra1] : '0;
  assign rdata2  = in_range(bus.ra2) ? mem[bus.ra2] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem[clr_addr] <= '0;
      end else if (user_we) begin
        mem[bus.wa] <= bus.wd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      if (bus.re1) begin
        if (clr_we)    rd1_q <= '0;
        else if (byp1) rd1_q <= bus.wd;
        else           rd1_q <= rdata1;
      end
      if (bus.re2) begin
        if (clr_we)    rd2_q <= '0;
        else if (byp2) rd2_q <= bus.wd;
        else           rd2_q <= rdata2;
      end
    end
  end

  assign bus.rd1  = rd1_q;
  assign bus.rd2  = rd2_q;
  assign bus.busy = busy;

endmodule

// File: tb/tb_sram_array_2r1w.sv
module tb_sram_array_2r1w;

  logic clk;
  logic rst;
  logic rst10;
  int   n_cmp;
  int   n_bad;

  sram_array_2r1w_if #(.WIDTH(8), .DEPTH(16)) b16 ();
  sram_array_2r1w_if #(.WIDTH(8), .DEPTH(10)) b10 ();

  sram_array_2r1w #(.WIDTH(8), .DEPTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (b16.slave)
  );

  sram_array_2r1w #(.WIDTH(8), .DEPTH(10)) dut10 (
    .clk (clk),
    .rst (rst10),
    .bus (b10.slave)
  );

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       re1;
    logic [3:0] ra1;
    logic       re2;
    logic [3:0] ra2;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;

  vec_t vecs [9];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic quiet16();
    b16.clr = 1'b0; b16.we = 1'b0; b16.wa = '0; b16.wd = '0;
    b16.re1 = 1'b0; b16.ra1 = '0; b16.re2 = 1'b0; b16.ra2 = '0;
  endtask

  task automatic quiet10();
    b10.clr = 1'b0; b10.we = 1'b0; b10.wa = '0; b10.wd = '0;
    b10.re1 = 1'b0; b10.ra1 = '0; b10.re2 = 1'b0; b10.ra2 = '0;
  endtask

  task automatic busy_len16(input string name, input int exp);
    int n;
    n = 0;
    while (b16.busy && n < 40) begin
      tick();
      n++;
    end
    check(name, n, exp);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    vecs[0] = '{1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 4'd6, 8'h11, 1'b1, 4'd3, 1'b1, 4'd3, 8'hA5, 8'hA5};
    vecs[2] = '{1'b1, 4'd5, 8'h3C, 1'b1, 4'd5, 1'b1, 4'd6, 8'h3C, 8'h11};
    vecs[3] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b1, 4'd5, 8'hA5, 8'h3C};
    vecs[4] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd9, 1'b0, 4'd6, 8'hA5, 8'h3C};
    vecs[5] = '{1'b1, 4'd3, 8'h5A, 1'b0, 4'd5, 1'b1, 4'd3, 8'hA5, 8'h5A};
    vecs[6] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b1, 4'd6, 8'h5A, 8'h11};
    vecs[7] = '{1'b1, 4'd7, 8'h77, 1'b1, 4'd7, 1'b1, 4'd7, 8'h77, 8'h77};
    vecs[8] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 1'b1, 4'd0, 8'h77, 8'h00};

    quiet16();
    quiet10();
    rst   = 1'b1;
    rst10 = 1'b1;

    // Reset state and initial clear length
    tick();
    tick();
    check("rst_busy", b16.busy, 1);
    check("rst_rd1", b16.rd1, 8'h00);
    check("rst_rd2", b16.rd2, 8'h00);
    rst = 1'b0;
    busy_len16("init_busy_len", 16);

    for (int a = 0; a < 16; a++) begin
      b16.re1 = 1'b1; b16.ra1 = 4'(a);
      b16.re2 = 1'b1; b16.ra2 = 4'(15 - a);
      tick();
      check($sformatf("init_rd1[%0d]", a), b16.rd1, 8'h00);
      check($sformatf("init_rd2[%0d]", 15 - a), b16.rd2, 8'h00);
    end
    quiet16();

    // Table-driven write / read / bypass / hold vectors
    for (int i = 0; i < 9; i++) begin
      b16.we  = vecs[i].we;  b16.wa  = vecs[i].wa;  b16.wd = vecs[i].wd;
      b16.re1 = vecs[i].re1; b16.ra1 = vecs[i].ra1;
      b16.re2 = vecs[i].re2; b16.ra2 = vecs[i].ra2;
      tick();
      check($sformatf("vec%0d_rd1", i), b16.rd1, vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), b16.rd2, vecs[i].e2);
    end
    quiet16();

    // Fill, then clear with a colliding write
    for (int a = 0; a < 16; a++) begin
      b16.we = 1'b1; b16.wa = 4'(a); b16.wd = 8'(8'h80 + a);
      tick();
    end
    quiet16();
    b16.re1 = 1'b1; b16.ra1 = 4'd2; b16.re2 = 1'b1; b16.ra2 = 4'd15;
    tick();
    check("fill_rd1", b16.rd1, 8'h82);
    check("fill_rd2", b16.rd2, 8'h8F);

    quiet16();
    b16.clr = 1'b1; b16.we = 1'b1; b16.wa = 4'd2; b16.wd = 8'hFF;
    tick();
    check("clr_busy_rise", b16.busy, 1);
    quiet16();
    b16.we = 1'b1; b16.wa = 4'd4; b16.wd = 8'hFF;
    b16.re1 = 1'b1; b16.ra1 = 4'd2;
    begin
      int n;
      int bad_rd;
      n = 0;
      bad_rd = 0;
      while (b16.busy && n < 40) begin
        tick();
        n++;
        if (b16.rd1 !== 8'h00) bad_rd++;
      end
      check("clr_busy_len", n, 16);
      check("clr_reads_during_busy", bad_rd, 0);
    end
    quiet16();
    for (int a = 0; a < 16; a++) begin
      b16.re1 = 1'b1; b16.ra1 = 4'(a);
      b16.re2 = 1'b1; b16.ra2 = 4'(15 - a);
      tick();
      check($sformatf("post_clr_rd1[%0d]", a), b16.rd1, 8'h00);
      check($sformatf("post_clr_rd2[%0d]", 15 - a), b16.rd2, 8'h00);
    end
    quiet16();

    // Reset in the middle of a clear
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check("midclr_busy_before", b16.busy, 1);
    rst = 1'b1;
    tick();
    check("midclr_busy_in_rst", b16.busy, 1);
    rst = 1'b0;
    busy_len16("midclr_busy_len", 16);

    // Non-power-of-2 depth
    rst10 = 1'b0;
    begin
      int n;
      n = 0;
      while (b10.busy && n < 40) begin
        tick();
        n++;
      end
      check("d10_busy_len", n, 10);
    end
    b10.we = 1'b1; b10.wa = 4'd12; b10.wd = 8'hEE;
    b10.re1 = 1'b1; b10.ra1 = 4'd12; b10.re2 = 1'b1; b10.ra2 = 4'd2;
    tick();
    check("d10_oor_bypass_rd1", b10.rd1, 8'h00);
    check("d10_rd2_a", b10.rd2, 8'h00);
    b10.we = 1'b1; b10.wa = 4'd2; b10.wd = 8'h22;
    tick();
    check("d10_oor_rd1", b10.rd1, 8'h00);
    check("d10_bypass_rd2", b10.rd2, 8'h22);
    b10.we = 1'b0; b10.ra2 = 4'd9;
    tick();
    check("d10_oor_rd1_b", b10.rd1, 8'h00);
    check("d10_last_rd2", b10.rd2, 8'h00);
    b10.ra1 = 4'd2; b10.ra2 = 4'd12;
    tick();
    check("d10_rd1_stored", b10.rd1, 8'h22);
    check("d10_oor_rd2", b10.rd2, 8'h00);
    quiet10();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
